eco32_core_lsu_dcu_xfer: RTL
============================

# eco32_core_lsu_dcu_xfer

Line-transfer sequencer for the ECO32 data cache unit, sitting directly on the external (`x`) port of the data-cache byte memory. For each accepted command it does one of three things: walks the 8 byte offsets of a page and packs the read-back bytes and per-byte dirty flags into one 64-bit write-back beat; unpacks one 64-bit refill beat into 8 byte writes; or does both in sequence. Byte writes on the `x` port always clear the byte's dirty flag inside the memory.

## Interface
- `PAGE_ADDR_WIDTH`, 5, page index width; must match the attached memory.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `i_stb` in 1: command request; accepted when `i_stb && o_rdy`.
- `i_op` in 2: 01 flush, 10 refill, 11 flush then refill; 00 is accepted and completes as a no-op.
- `i_tid`, `i_wid` in 1 each: thread and way select.
- `i_page` in PAGE_ADDR_WIDTH: page index.
- `o_rdy` out 1: block idle, command can be taken.
- `o_done` out 1: one-cycle completion pulse.
- `xo_stb`, `xo_wen` out 1 each: memory x-port strobe and write enable.
- `xo_tid`, `xo_wid` out 1 each: memory x-port thread and way select.
- `xo_page` out PAGE_ADDR_WIDTH: memory x-port page index.
- `xo_offset` out 3: memory x-port byte offset.
- `xo_data` out 8: memory x-port write data.
- `xi_val`, `xi_ben` in 1 each: memory read-valid and dirty flag, one cycle after a read strobe.
- `xi_data` in 8: memory read data.
- `wb_stb` out 1: write-back beat valid.
- `wb_ack` in 1: bus accepted the beat.
- `wb_tid`, `wb_wid` out 1 each: write-back thread and way.
- `wb_page` out PAGE_ADDR_WIDTH: write-back page index.
- `wb_mask` out 8: dirty-byte mask.
- `wb_data` out 64: write-back data.
- `rf_stb` in 1: refill beat valid.
- `rf_data` in 64: refill data.
- `rf_ack` out 1: one-cycle pulse, refill beat consumed.

## Operation
- FSM states: IDLE, RD, COL, WB, RFW, WR, DONE. All outputs are registered.
- IDLE: `o_rdy`=1. On accept, latch `tid`/`wid`/`page`/`op`, clear `wb_mask`, then:
  - op bit0 set: go to RD.
  - else op bit1 set: go to RFW.
  - else: go to DONE.
- RD: 8 cycles with `xo_stb`=1, `xo_wen`=0, `xo_offset`=0..7 ascending, then go to COL.
- Collection runs on a separate 3-bit arrival counter. Each `xi_val` cycle stores:
  - `xi_data` into `wb_data[8k+7:8k]`;
  - `xi_ben` into `wb_mask[k]`;
  - where k is the arrival count, then the counter increments.
  - `xi_val` outside RD/COL is ignored.
- COL: wait until the 8th byte has been stored.
  - `wb_mask` nonzero: go to WB.
  - `wb_mask` all zero: skip the bus beat and go to RFW if op bit1, else DONE.
- WB: `wb_stb`=1 with `wb_data`/`wb_mask`/`wb_tid`/`wb_wid`/`wb_page` held stable until `wb_ack` is sampled 1. Then go to RFW if op bit1, else DONE.
- RFW: wait for `rf_stb`. When sampled, latch `rf_data`, pulse `rf_ack`, go to WR.
- WR: 8 cycles with `xo_stb`=1, `xo_wen`=1, `xo_offset`=0..7, `xo_data`=`rf_data[8k+7:8k]`. Then go to DONE.
- DONE: `o_done`=1 for one cycle, then return to IDLE.
- `i_stb` while `o_rdy`=0 is neither acknowledged nor queued. `wb_ack` outside WB and `rf_stb` outside RFW are ignored.
- `xo_tid`, `xo_wid`, `xo_page` carry the latched command fields whenever `xo_stb`=1.

## Timing
- Reset values: all outputs 0, including `o_rdy`, `wb_data` and `wb_mask`. `o_rdy` rises in the first cycle after reset is released.
- Cycle 0 is the accept cycle; `o_rdy` is 0 from cycle 1.
- Flush, back-to-back reads: `xo_stb` in cycles 1..8, `xi_val` expected in cycles 2..9.
  - `wb_stb` rises in cycle 10 at the earliest.
  - With zero mask, `o_done` is in cycle 11 (flush only).
- Write-back handshake: with `wb_ack` high in cycle N, `wb_stb` is 0 in cycle N+1. `o_done` is in N+2 (flush only).
- Refill: with `rf_stb` first sampled in cycle M, `rf_ack` is in M+1, writes are in cycles M+2..M+9, `o_done` is in M+10.
- Earliest next accept is the cycle after `o_done`.
- Memory read latency is fixed at 1. The block does not tolerate gaps in `xi_val`.
- Reset mid-operation: immediate return to IDLE, outputs to 0, command dropped. Partially refilled memory content is left as is.

## Test plan
- Flush, page 3, tid 1, wid 0, memory bytes 0x10..0x17, dirty bytes 1 and 6 only:
  - `wb_stb` in cycle 10 with `wb_data`=0x1716151413121110 and `wb_mask`=0x42;
  - ack after 3 cycles; `o_done` follows 2 cycles after the ack.
- Flush with no dirty bytes: no `wb_stb`; `o_done` in cycle 11.
- Refill, `rf_data`=0x8877665544332211:
  - writes 0x11..0x88 to offsets 0..7, `rf_ack` single pulse;
  - memory dirty flags read back 0.
- Op 11 with all bytes dirty:
  - `wb_mask`=0xFF beat, then refill;
  - `rf_stb` held high during WB is ignored until RFW.
- `i_stb` asserted during busy: no second accept. `rst` pulled low in cycle 5 of RD: all outputs 0 and `o_rdy`=1 one cycle after release.

Source files
------------

// File: rtl/eco32_core_lsu_dcu_xfer_if.sv
// ---------------------------------------------------------------------------
// eco32_core_lsu_dcu_xfer_if
//
// Purpose: bundles every handshake and bus signal of the DCU line-transfer
// sequencer so the sequencer and its environment share one connection.
//
// Signal groups:
//   command   : i_stb, i_op, i_tid, i_wid, i_page  -> o_rdy, o_done
//   x-port    : xo_stb, xo_wen, xo_tid, xo_wid, xo_page, xo_offset, xo_data
//               <- xi_val, xi_ben, xi_data  (byte memory, read latency 1)
//   write-back: wb_stb, wb_tid, wb_wid, wb_page, wb_mask, wb_data <- wb_ack
//   refill    : rf_stb, rf_data -> rf_ack
//
// Modports:
//   master : the sequencer itself
//   slave  : the surrounding LSU, byte memory and external bus
// ---------------------------------------------------------------------------
interface eco32_core_lsu_dcu_xfer_if #(
    parameter int PAGE_ADDR_WIDTH = 5
);
    logic                       i_stb;
    logic [1:0]                 i_op;
    logic                       i_tid;
    logic                       i_wid;
    logic [PAGE_ADDR_WIDTH-1:0] i_page;
    logic                       o_rdy;
    logic                       o_done;

    logic                       xo_stb;
    logic                       xo_wen;
    logic                       xo_tid;
    logic                       xo_wid;
    logic [PAGE_ADDR_WIDTH-1:0] xo_page;
    logic [2:0]                 xo_offset;
    logic [7:0]                 xo_data;
    logic                       xi_val;
    logic                       xi_ben;
    logic [7:0]                 xi_data;

    logic                       wb_stb;
    logic                       wb_ack;
    logic                       wb_tid;
    logic                       wb_wid;
    logic [PAGE_ADDR_WIDTH-1:0] wb_page;
    logic [7:0]                 wb_mask;
    logic [63:0]                wb_data;

    logic                       rf_stb;
    logic [63:0]                rf_data;
    logic                       rf_ack;

    modport master (
        input  i_stb, i_op, i_tid, i_wid, i_page,
        output o_rdy, o_done,
        output xo_stb, xo_wen, xo_tid, xo_wid, xo_page, xo_offset, xo_data,
        input  xi_val, xi_ben, xi_data,
        output wb_stb, wb_tid, wb_wid, wb_page, wb_mask, wb_data,
        input  wb_ack,
        input  rf_stb, rf_data,
        output rf_ack
    );

    modport slave (
        output i_stb, i_op, i_tid, i_wid, i_page,
        input  o_rdy, o_done,
        input  xo_stb, xo_wen, xo_tid, xo_wid, xo_page, xo_offset, xo_data,
        output xi_val, xi_ben, xi_data,
        input  wb_stb, wb_tid, wb_wid, wb_page, wb_mask, wb_data,
        output wb_ack,
        output rf_stb, rf_data,
        input  rf_ack
    );
endinterface

// File: rtl/eco32_core_lsu_dcu_xfer.sv
// ---------------------------------------------------------------------------
// eco32_core_lsu_dcu_xfer
//
// Purpose: line-transfer sequencer on the external port of the data-cache
// byte memory. A flush reads the 8 bytes of a page and packs data plus dirty
// flags into one 64-bit write-back beat (skipped when nothing is dirty). A
// refill unpacks one 64-bit beat into 8 byte writes, which also clear the
// dirty flags inside the memory. Op 11 does a flush followed by a refill.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : command, x-port, write-back and refill signals (master modport)
// ---------------------------------------------------------------------------
module eco32_core_lsu_dcu_xfer #(
    parameter int PAGE_ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    eco32_core_lsu_dcu_xfer_if.master     bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_COL  = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_RFW  = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]                 r_state;
    logic                       r_op_refill;
    logic                       r_tid;
    logic                       r_wid;
    logic [PAGE_ADDR_WIDTH-1:0] r_page;
    logic                       r_rdy;
    logic                       r_done;
    logic                       r_xo_stb;
    logic                       r_xo_wen;
    logic [2:0]                 r_xo_offset;
    logic [7:0]                 r_xo_data;
    logic [2:0]                 r_arr_cnt;
    logic                       r_wb_stb;
    logic [7:0]                 r_wb_mask;
    logic [63:0]                r_wb_data;
    logic [63:0]                r_rf_data;
    logic                       r_rf_ack;

    logic                       w_collect;
    logic                       w_last_byte;
    logic [7:0]                 w_mask_next;
    logic [2:0]                 w_off_inc;

    // Read data returns one cycle after each strobe, so arrivals are counted
    // separately from the issued offsets; arrivals outside RD/COL are stale.
    assign w_collect   = bus.xi_val && ((r_state == S_RD) || (r_state == S_COL));
    assign w_last_byte = w_collect && (r_arr_cnt == 3'd7);
    assign w_off_inc   = r_xo_offset + 3'd1;

    // The mask including the byte arriving this cycle lets COL decide on the
    // same edge that stores the 8th byte.
    always_comb begin
        w_mask_next = r_wb_mask;
        if (w_collect) begin
            w_mask_next[r_arr_cnt] = bus.xi_ben;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_op_refill <= 1'b0;
            r_tid       <= 1'b0;
            r_wid       <= 1'b0;
            r_page      <= '0;
            r_rdy       <= 1'b0;
            r_done      <= 1'b0;
            r_xo_stb    <= 1'b0;
            r_xo_wen    <= 1'b0;
            r_xo_offset <= 3'd0;
            r_xo_data   <= 8'd0;
            r_arr_cnt   <= 3'd0;
            r_wb_stb    <= 1'b0;
            r_wb_mask   <= 8'd0;
            r_wb_data   <= 64'd0;
            r_rf_data   <= 64'd0;
            r_rf_ack    <= 1'b0;
        end else begin
            if (w_collect) begin
                r_wb_data[{r_arr_cnt, 3'b000} +: 8] <= bus.xi_data;
                r_wb_mask                           <= w_mask_next;
                r_arr_cnt                           <= r_arr_cnt + 3'd1;
            end

            case (r_state)
                // o_rdy is raised one cycle after entering IDLE, which keeps
                // the o_done cycle closed to new commands.
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (!r_rdy) begin
                        r_rdy <= 1'b1;
                    end else if (bus.i_stb) begin
                        r_rdy       <= 1'b0;
                        r_op_refill <= bus.i_op[1];
                        r_tid       <= bus.i_tid;
                        r_wid       <= bus.i_wid;
                        r_page      <= bus.i_page;
                        r_wb_mask   <= 8'd0;
                        r_arr_cnt   <= 3'd0;
                        if (bus.i_op[0]) begin
                            r_state     <= S_RD;
                            r_xo_stb    <= 1'b1;
                            r_xo_wen    <= 1'b0;
                            r_xo_offset <= 3'd0;
                        end else if (bus.i_op[1]) begin
                            r_state <= S_RFW;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RD: begin
                    if (r_xo_offset == 3'd7) begin
                        r_xo_stb <= 1'b0;
                        r_state  <= S_COL;
                    end else begin
                        r_xo_offset <= w_off_inc;
                    end
                end
                S_COL: begin
                    if (w_last_byte) begin
                        if (w_mask_next != 8'd0) begin
                            r_wb_stb <= 1'b1;
                            r_state  <= S_WB;
                        end else if (r_op_refill) begin
                            r_state <= S_RFW;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WB: begin
                    if (bus.wb_ack) begin
                        r_wb_stb <= 1'b0;
                        r_state  <= r_op_refill ? S_RFW : S_DONE;
                    end
                end
                S_RFW: begin
                    if (bus.rf_stb) begin
                        r_rf_data <= bus.rf_data;
                        r_rf_ack  <= 1'b1;
                        r_state   <= S_WR;
                    end
                end
                // First WR cycle only sets up offset 0; the state moves to
                // DONE while offset 7 is on the port so o_done follows the
                // last write directly.
                S_WR: begin
                    r_rf_ack <= 1'b0;
                    if (!r_xo_stb) begin
                        r_xo_stb    <= 1'b1;
                        r_xo_wen    <= 1'b1;
                        r_xo_offset <= 3'd0;
                        r_xo_data   <= r_rf_data[7:0];
                    end else begin
                        r_xo_offset <= w_off_inc;
                        r_xo_data   <= r_rf_data[{w_off_inc, 3'b000} +: 8];
                        if (w_off_inc == 3'd7) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_xo_stb <= 1'b0;
                    r_xo_wen <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_rdy     = r_rdy;
    assign bus.o_done    = r_done;
    assign bus.xo_stb    = r_xo_stb;
    assign bus.xo_wen    = r_xo_wen;
    assign bus.xo_tid    = r_tid;
    assign bus.xo_wid    = r_wid;
    assign bus.xo_page   = r_page;
    assign bus.xo_offset = r_xo_offset;
    assign bus.xo_data   = r_xo_data;
    assign bus.wb_stb    = r_wb_stb;
    assign bus.wb_tid    = r_tid;
    assign bus.wb_wid    = r_wid;
    assign bus.wb_page   = r_page;
    assign bus.wb_mask   = r_wb_mask;
    assign bus.wb_data   = r_wb_data;
    assign bus.rf_ack    = r_rf_ack;

endmodule
